// File: rtl/segway_cmd_pkg.sv
// segway_cmd_pkg: command byte codes and state encodings shared by the rider command receiver.
package segway_cmd_pkg;
    localparam logic [7:0] CMD_START = 8'h47;
    localparam logic [7:0] CMD_STOP  = 8'h53;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {AUTH_OFF, AUTH_PWR1, AUTH_PWR2} auth_state_t;
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver with 2-flop input synchronizer; AUTH_FRAME_CHECK_EN drops frames with a bad stop bit.
module uart_rx_core
    import segway_cmd_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       rdy,
    output logic [7:0] rx_data,
    output logic       frm_err
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
    rx_state_t     state;
    logic [2:0]    sync;
    logic [CW-1:0] baud;
    logic [3:0]    bits;
    logic [7:0]    shreg;
    logic          rx_s;
    logic          fall;
    // sync[1] is the synchronized line, sync[2] its previous value for edge detection
    assign rx_s    = sync[1];
    assign fall    = sync[2] & ~sync[1];
    assign rx_data = shreg;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync    <= 3'b111;
            state   <= RX_IDLE;
            baud    <= '0;
            bits    <= '0;
            shreg   <= '0;
            rdy     <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            sync    <= {sync[1:0], rx};
            rdy     <= 1'b0;
            frm_err <= 1'b0;
            baud    <= baud + 1'b1;
            case (state)
                RX_IDLE: if (fall) begin
                    state <= RX_START;
                    baud  <= '0;
                    bits  <= '0;
                end
                RX_START: if (baud == HALF) begin
                    state <= rx_s ? RX_IDLE : RX_DATA;
                    baud  <= '0;
                    bits  <= '0;
                end
                RX_DATA: if (baud == FULL) begin
                    shreg <= {rx_s, shreg[7:1]};
                    baud  <= '0;
                    bits  <= (bits == 4'd7) ? 4'd0 : bits + 4'd1;
                    state <= (bits == 4'd7) ? RX_STOP : RX_DATA;
                end
                RX_STOP: if (baud == FULL) begin
                    state <= RX_IDLE;
                    baud  <= '0;
                    bits  <= '0;
`ifdef AUTH_FRAME_CHECK_EN
                    rdy     <= rx_s;
                    frm_err <= ~rx_s;
`else
                    rdy     <= 1'b1;
`endif
                end
                default: state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/auth_cmd_rx.sv
// auth_cmd_rx: decodes 'G'/'S' rider commands into the pwr_up enable; frm_err is live only with AUTH_FRAME_CHECK_EN.
module auth_cmd_rx
    import segway_cmd_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       rider_off,
    output logic       pwr_up,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       frm_err
);
    auth_state_t state;
    auth_state_t nxt;
    logic        rdy;
    logic        core_err;
    logic [7:0]  rx_data;
    uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (RX),
        .rdy     (rdy),
        .rx_data (rx_data),
        .frm_err (core_err)
    );
    // rider_off leaving PWR2 outranks any byte arriving in the same cycle
    always_comb begin
        nxt = (state == AUTH_PWR2 && rider_off) ? AUTH_OFF :
              !cmd_valid ? state :
              (state == AUTH_OFF && cmd_byte == CMD_START) ? AUTH_PWR1 :
              (state == AUTH_PWR1 && cmd_byte == CMD_STOP) ? (rider_off ? AUTH_OFF : AUTH_PWR2) :
              (state == AUTH_PWR2 && cmd_byte == CMD_START) ? AUTH_PWR1 : state;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= AUTH_OFF;
            pwr_up    <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_byte  <= 8'h00;
            frm_err   <= 1'b0;
        end else begin
            state     <= nxt;
            pwr_up    <= (nxt != AUTH_OFF);
            cmd_valid <= rdy;
            frm_err   <= core_err;
            if (rdy) cmd_byte <= rx_data;
        end
    end
endmodule

// File: tb/tb_auth_cmd_rx.sv
// tb_auth_cmd_rx: directed frames against auth_cmd_rx with a short bit time; honours AUTH_FRAME_CHECK_EN.
module tb_auth_cmd_rx;
    import segway_cmd_pkg::*;
    localparam int B = 16;
    logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, rider_off = 1'b0;
    logic pwr_up, cmd_valid, frm_err;
    logic [7:0] cmd_byte;
    int errors = 0, checks = 0, vcnt = 0, fcnt = 0, both = 0, vsave = 0;
    logic pend = 1'b0, pwr_at_valid = 1'b0, pwr_after = 1'b0;
    logic [7:0] last_byte = 8'h00;

    always #5 clk = ~clk;

    auth_cmd_rx #(.BAUD_DIV(B)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (rx),
        .rider_off (rider_off),
        .pwr_up    (pwr_up),
        .cmd_valid (cmd_valid),
        .cmd_byte  (cmd_byte),
        .frm_err   (frm_err)
    );

    always @(negedge clk) begin
        if (cmd_valid) begin
            vcnt         <= vcnt + 1;
            last_byte    <= cmd_byte;
            pwr_at_valid <= pwr_up;
            pend         <= 1'b1;
        end else if (pend) begin
            pwr_after <= pwr_up;
            pend      <= 1'b0;
        end
        if (frm_err) fcnt <= fcnt + 1;
        if (cmd_valid && frm_err) both <= both + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input int idle);
        rx = 1'b0;
        cyc(B);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            cyc(B);
        end
        rx = stop;
        cyc(B);
        rx = 1'b1;
        cyc(idle);
    endtask

    initial begin
        cyc(3);
        check("rst_pwr_up", pwr_up, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_frm_err", frm_err, 0);
        check("rst_cmd_byte", cmd_byte, 8'h00);
        rst_n = 1'b1;
        cyc(2);

        send(CMD_START, 1'b1, 4);
        check("g_count", vcnt, 1);
        check("g_byte", last_byte, 8'h47);
        check("g_pwr_at_valid", pwr_at_valid, 0);
        check("g_pwr_after", pwr_after, 1);

        send(CMD_STOP, 1'b1, 4);
        check("s_rider_on_count", vcnt, 2);
        check("s_rider_on_pwr", pwr_up, 1);
        rider_off = 1'b1;
        check("pwr2_before_edge", pwr_up, 1);
        cyc(1);
        check("pwr2_rider_off", pwr_up, 0);

        rider_off = 1'b0;
        send(CMD_START, 1'b1, 4);
        check("g2_pwr", pwr_up, 1);
        rider_off = 1'b1;
        send(CMD_STOP, 1'b1, 4);
        check("s_rider_off_at_valid", pwr_at_valid, 1);
        check("s_rider_off_after", pwr_after, 0);

        rider_off = 1'b0;
        send(CMD_STOP, 1'b1, 4);
        check("off_s_byte", cmd_byte, 8'h53);
        check("off_s_pwr", pwr_up, 0);
        send(8'h41, 1'b1, 4);
        check("off_a_byte", cmd_byte, 8'h41);
        check("off_a_count", vcnt, 6);
        check("off_a_pwr", pwr_up, 0);

        send(CMD_START, 1'b0, 4);
`ifdef AUTH_FRAME_CHECK_EN
        check("ferr_count", fcnt, 1);
        check("ferr_no_valid", vcnt, 6);
        check("ferr_pwr", pwr_up, 0);
        check("ferr_byte_held", cmd_byte, 8'h41);
        send(CMD_START, 1'b1, 4);
`else
        check("nostop_count", vcnt, 7);
        check("nostop_pwr", pwr_up, 1);
        check("nostop_byte", cmd_byte, 8'h47);
`endif
        check("pwr1_ready", pwr_up, 1);

        vsave = vcnt;
        rx = 1'b0;
        cyc(B / 4);
        rx = 1'b1;
        cyc(3 * B);
        check("glitch_no_pulse", vcnt, vsave);
        check("glitch_pwr_kept", pwr_up, 1);

        rx = 1'b0;
        cyc(B);
        rx = 1'b1;
        cyc(2 * B);
        rx = 1'b0;
        cyc(B / 2);
        rst_n = 1'b0;
        cyc(2);
        rx = 1'b1;
        check("midrst_pwr", pwr_up, 0);
        rst_n = 1'b1;
        cyc(12 * B);
        check("midrst_no_pulse", vcnt, vsave);
        check("midrst_byte", cmd_byte, 8'h00);

        send(CMD_START, 1'b1, 0);
        send(CMD_STOP, 1'b1, 4);
        check("b2b_count", vcnt, vsave + 2);
        check("b2b_byte", last_byte, 8'h53);
        check("b2b_pwr", pwr_up, 1);

        check("never_both", both, 0);
`ifdef AUTH_FRAME_CHECK_EN
        check("ferr_total", fcnt, 1);
`else
        check("ferr_total", fcnt, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/auth_cmd_rx.md
# auth_cmd_rx

Receive side of the rider command link. Deserializes 8N1 UART bytes on `RX`, decodes the 'G' (0x47) start and 'S' (0x53) stop commands, and combines them with the `rider_off` qualifier to drive the `pwr_up` enable that gates the balance controller and motor drive. Sits between the top-level `RX` pin and the balance/steering logic; it is the far end of the bench's UART command transmitter.

## Interface
- `BAUD_DIV`, 5208: clocks per bit (50 MHz / 9600 baud); minimum 16.
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `RX`  in  1: asynchronous serial input; idles high.
- `rider_off`  in  1: high when the load cells report no rider.
- `pwr_up`  out  1: high while the Segway is authorized to balance.
- `cmd_valid`  out  1: one-cycle pulse when a byte has been received.
- `cmd_byte`  out  8: last received byte; holds until the next byte.
- `frm_err`  out  1: one-cycle pulse on a bad stop bit (only with `AUTH_FRAME_CHECK_EN`).

## Operation
- `RX` passes through a 2-flop synchronizer whose flops preset high. All logic uses the synchronized value.
- **Receiver FSM**
  - States: IDLE, START, DATA, STOP.
  - IDLE→START on a synced falling edge.
  - START: wait `BAUD_DIV/2` cycles, then resample. If low, go to DATA. If high, the start was a glitch: return to IDLE with no pulse.
  - DATA: sample every `BAUD_DIV` cycles. Shift LSB-first into an 8-bit register. Go to STOP after 8 samples.
  - STOP: sample once after `BAUD_DIV` cycles, then return to IDLE.
  - Counters: a 13-bit baud counter (sized from `BAUD_DIV` with `$clog2`) and a 4-bit bit counter. Both clear on every state entry.
- **Byte accept**
  - At the stop sample, `cmd_byte` loads the shift register and `cmd_valid` pulses.
  - With frame check enabled and stop bit = 0: no load, no `cmd_valid`, `frm_err` pulses instead.
- **Auth FSM**
  - States: OFF, PWR1, PWR2. Evaluated only in cycles where `cmd_valid` is high, except for the `rider_off` exit from PWR2.
  - OFF: 'G' → PWR1. All other bytes are ignored.
  - PWR1: 'S' with `rider_off`=1 → OFF. 'S' with `rider_off`=0 → PWR2. Other bytes, including 'G', are ignored.
  - PWR2: `rider_off`=1 in any cycle → OFF. 'G' → PWR1. If `rider_off`=1 and 'G' arrive in the same cycle, `rider_off` wins → OFF.
  - `pwr_up` = (state ≠ OFF), registered.

## Timing
- Reset values: `pwr_up`=0, `cmd_valid`=0, `frm_err`=0, `cmd_byte`=0x00; receiver in IDLE; auth FSM in OFF.
- Reset applied mid-frame aborts the frame: no pulse, and the partial byte is discarded.
- Latency from the synced falling edge of the start bit to `cmd_valid`: `BAUD_DIV/2 + 9·BAUD_DIV + 1` cycles. The synchronizer adds 2 more cycles from the pin.
- `pwr_up` changes exactly 1 cycle after the `cmd_valid` that causes the transition. In PWR2 it falls 1 cycle after `rider_off` rises.
- `cmd_valid` and `frm_err` are never high together and are each high for exactly 1 cycle.
- Back-to-back frames: a new start bit seen in the cycle after the STOP sample is accepted. There is no idle-gap requirement beyond the stop bit itself.
- `RX` stuck low after a framing error: no new frame starts until `RX` returns high, because a falling edge is required.

## Configuration
- `AUTH_FRAME_CHECK_EN` defined:
  - A stop bit sampled as 0 discards the byte and pulses `frm_err`.
  - The auth FSM sees nothing from that frame.
- `AUTH_FRAME_CHECK_EN` undefined:
  - The stop-bit value is ignored and every frame produces `cmd_valid`.
  - `frm_err` is tied to 0.

## Structure
- Shared package `segway_cmd_pkg` holds:
  - `CMD_START`=8'h47 and `CMD_STOP`=8'h53, also imported by the bench.
  - The receiver-state and auth-state enum typedefs.
- Sub-module `uart_rx_core` contains the synchronizer, receiver FSM and counters. It outputs `rdy`, `rx_data` and `frm_err`.
- `auth_cmd_rx` instantiates `uart_rx_core` and implements the auth FSM and output registers.

## Test plan
- Rider on (`rider_off`=0), send 0x47 → `cmd_valid` pulses, `cmd_byte`=0x47, and `pwr_up` rises 1 cycle later.
- In PWR1 with `rider_off`=0, send 0x53 → `pwr_up` stays 1 (PWR2). Then raise `rider_off` → `pwr_up`=0 on the next cycle.
- In PWR1 with `rider_off`=1, send 0x53 → `pwr_up`=0 one cycle after `cmd_valid`.
- In OFF, send 0x53, then 0x41 → both are received (`cmd_byte` updates) and `pwr_up` stays 0.
- Send a frame with stop bit 0 carrying 0x47:
  - With `AUTH_FRAME_CHECK_EN` defined: `frm_err` pulses and `pwr_up` stays 0.
  - With it undefined: `pwr_up`=1.
- A 0.25-bit low glitch on `RX` → no pulse. Asserting `rst_n`=0 mid-frame in PWR1 → `pwr_up`=0 and `cmd_valid` never pulses for that frame.
